sprite_attr_writer: RTL and testbench

SPRITE_ATTR_WRITER -- requirements
Module: sprite_attr_writer

---
 rtl/sprite_attr_writer_pkg.sv | 32 +++
 rtl/sprite_attr_writer_sync_fifo.sv | 72 +++++++
 rtl/sprite_attr_writer.sv | 119 +++++++++++
 tb/tb_sprite_attr_writer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_attr_writer_pkg.sv
// rtl/sprite_attr_writer_pkg.sv - shared constants and types for the sprite attribute writer
package sprite_attr_writer_pkg;

  localparam logic [10:0] SPRITE_BASE = 11'h001;
  localparam int          FIFO_DEPTH  = 8;
  localparam int          NUM_SPRITES = 8;
  localparam int          NUM_REGS    = 4;
  localparam int          TABLE_WORDS = NUM_SPRITES * NUM_REGS;
  localparam int          DATA_W      = 16;
  localparam int          ENTRY_W     = 5 + DATA_W;

  localparam logic [1:0] REG_X    = 2'd0;
  localparam logic [1:0] REG_Y    = 2'd1;
  localparam logic [1:0] REG_TILE = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

  // addr is {sprite, reg}, which is also the flat table index.
  typedef struct packed {
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  function automatic logic is_sprite_addr(input logic [15:0] addr);
    return addr[15:5] == SPRITE_BASE;
  endfunction

endpackage

// File: rtl/sprite_attr_writer_sync_fifo.sv
// rtl/sprite_attr_writer_sync_fifo.sv - synchronous FIFO holding sprite writes until vblank
// Show-ahead read: pop_data is the head entry whenever empty is low.
module sync_fifo
  import sprite_attr_writer_pkg::*;
#(
  parameter  int WIDTH = ENTRY_W,
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign pop_ok   = pop && !empty;
  // A pop frees the head slot, so a push into a full FIFO can take it in the same cycle.
  assign push_ok  = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sprite_attr_writer.sv
// rtl/sprite_attr_writer.sv - queues stack-machine sprite writes and applies them to the attribute table during vblank
// The table is only modified while vblank is high so the renderer never sees a half-updated sprite.
module sprite_attr_writer
  import sprite_attr_writer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        write,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        vblank,
  input  logic [2:0]  rd_sprite,
  output logic [15:0] rd_x,
  output logic [15:0] rd_y,
  output logic [15:0] rd_tile,
  output logic [15:0] rd_ctrl,
  output logic [3:0]  pending,
  output logic        full,
  output logic        overflow
);

  drain_state_e state_q, state_d;
  logic         overflow_q, overflow_d;
  logic [15:0]  attr_q [TABLE_WORDS];
  logic [15:0]  attr_d [TABLE_WORDS];
  logic [15:0]  rd_x_q, rd_x_d;
  logic [15:0]  rd_y_q, rd_y_d;
  logic [15:0]  rd_tile_q, rd_tile_d;
  logic [15:0]  rd_ctrl_q, rd_ctrl_d;

  logic         sprite_wr;
  logic         pop;
  logic         push_ok;
  logic         fifo_full;
  logic         fifo_empty;
  logic [3:0]   fifo_count;
  fifo_entry_t  head;

  assign sprite_wr = write && is_sprite_addr(wr_addr);
  assign pop       = (state_q == ST_DRAIN) && vblank && !fifo_empty;
  assign push_ok   = sprite_wr && (!fifo_full || pop);

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (sprite_wr),
    .push_data ({wr_addr[4:0], wr_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (vblank && !fifo_empty) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave as soon as vblank ends or the pop just taken empties the queue.
        if (!vblank || fifo_empty || (pop && !push_ok && fifo_count == 4'd1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q | (sprite_wr & fifo_full & ~pop);
    attr_d     = attr_q;
    if (pop) begin
      attr_d[head.addr] = head.data;
    end
    // Read from the registered table so a same-edge write is seen one cycle later.
    rd_x_d    = attr_q[{rd_sprite, REG_X}];
    rd_y_d    = attr_q[{rd_sprite, REG_Y}];
    rd_tile_d = attr_q[{rd_sprite, REG_TILE}];
    rd_ctrl_d = attr_q[{rd_sprite, REG_CTRL}];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      overflow_q <= 1'b0;
      for (int i = 0; i < TABLE_WORDS; i++) begin
        attr_q[i] <= '0;
      end
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      rd_tile_q <= '0;
      rd_ctrl_q <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      attr_q     <= attr_d;
      rd_x_q     <= rd_x_d;
      rd_y_q     <= rd_y_d;
      rd_tile_q  <= rd_tile_d;
      rd_ctrl_q  <= rd_ctrl_d;
    end
  end

  assign rd_x     = rd_x_q;
  assign rd_y     = rd_y_q;
  assign rd_tile  = rd_tile_q;
  assign rd_ctrl  = rd_ctrl_q;
  assign pending  = fifo_count;
  assign full     = fifo_full;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_sprite_attr_writer.sv
// tb/tb_sprite_attr_writer.sv - self-checking bench for sprite_attr_writer against a queue/array model
module tb_sprite_attr_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        write;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        vblank;
  logic [2:0]  rd_sprite;
  logic [15:0] rd_x, rd_y, rd_tile, rd_ctrl;
  logic [3:0]  pending;
  logic        full;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  sprite_attr_writer dut (
    .clock     (clock),
    .reset     (reset),
    .write     (write),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .vblank    (vblank),
    .rd_sprite (rd_sprite),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_tile   (rd_tile),
    .rd_ctrl   (rd_ctrl),
    .pending   (pending),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  // Reference model: a queue of pending writes, a flat 32-word table, a draining flag.
  logic [15:0] m_tab [32];
  logic [20:0] mq [$];
  bit          m_drain;
  bit          m_ovf;
  logic [15:0] m_rd [4];
  int          m_sz;
  bit          m_pop;
  logic [20:0] m_e;

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_tab[i] = 16'h0;
      for (int k = 0; k < 4; k++) m_rd[k] = 16'h0;
      mq.delete();
      m_drain = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      m_sz  = mq.size();
      m_pop = m_drain && vblank && (m_sz != 0);
      for (int k = 0; k < 4; k++) m_rd[k] = m_tab[int'(rd_sprite) * 4 + k];
      if (m_pop) begin
        m_e = mq.pop_front();
        m_tab[m_e[20:16]] = m_e[15:0];
      end
      if (write && (wr_addr >= 16'h0020) && (wr_addr <= 16'h003F)) begin
        if (m_sz < 8 || m_pop) mq.push_back({wr_addr[4:0], wr_data});
        else m_ovf = 1'b1;
      end
      if (m_drain) m_drain = vblank && (m_sz != 0) && (mq.size() != 0);
      else         m_drain = vblank && (m_sz != 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (checking) begin
      check("model_rd_x",     32'(rd_x),     32'(m_rd[0]));
      check("model_rd_y",     32'(rd_y),     32'(m_rd[1]));
      check("model_rd_tile",  32'(rd_tile),  32'(m_rd[2]));
      check("model_rd_ctrl",  32'(rd_ctrl),  32'(m_rd[3]));
      check("model_pending",  32'(pending),  32'(mq.size()));
      check("model_full",     32'(full),     32'(mq.size() == 8));
      check("model_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    write   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    write   = 1'b0;
  endtask

  logic [15:0] bad_addrs [3];

  initial begin
    reset = 1'b1; write = 1'b0; wr_addr = '0; wr_data = '0; vblank = 1'b0; rd_sprite = '0;
    step(2);
    checking = 1'b1;
    reset = 1'b0;
    check("reset_pending",  32'(pending),  32'd0);
    check("reset_full",     32'(full),     32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_rd_x",     32'(rd_x),     32'd0);

    // Basic update: table changes two edges after the write, read shows it one edge later.
    vblank = 1'b1; rd_sprite = 3'd1;
    wr(16'h0024, 16'h0055);
    step(2);
    check("same_edge_old_rd_x", 32'(rd_x), 32'h0);
    step();
    check("basic_rd_x", 32'(rd_x), 32'h0055);

    // Decode filter.
    bad_addrs[0] = 16'h001F; bad_addrs[1] = 16'h0040; bad_addrs[2] = 16'h0120;
    for (int i = 0; i < 3; i++) begin
      wr(bad_addrs[i], 16'hBEEF);
      check("decode_pending", 32'(pending), 32'd0);
    end
    step(3);
    check("decode_rd_x", 32'(rd_x), 32'h0055);

    // Deferred drain.
    vblank = 1'b0; rd_sprite = 3'd2;
    wr(16'h002B, 16'h0007);
    for (int i = 0; i < 20; i++) begin
      step();
      check("defer_pending", 32'(pending), 32'd1);
      check("defer_rd_ctrl", 32'(rd_ctrl), 32'd0);
    end
    vblank = 1'b1;
    step(2);
    check("defer_drained", 32'(pending), 32'd0);
    step();
    check("defer_rd_ctrl_new", 32'(rd_ctrl), 32'h0007);

    // Overflow: ninth write is dropped.
    vblank = 1'b0;
    for (int i = 0; i < 9; i++) wr(16'(16'h0020 + i), 16'(16'h0100 + i));
    check("ovf_pending",  32'(pending),  32'd8);
    check("ovf_full",     32'(full),     32'd1);
    check("ovf_overflow", 32'(overflow), 32'd1);
    vblank = 1'b1;
    step(12);
    rd_sprite = 3'd0; step();
    check("ovf_s0_x", 32'(rd_x), 32'h0100);
    check("ovf_s0_ctrl", 32'(rd_ctrl), 32'h0103);
    rd_sprite = 3'd1; step();
    check("ovf_s1_x", 32'(rd_x), 32'h0104);
    check("ovf_s1_ctrl", 32'(rd_ctrl), 32'h0107);
    rd_sprite = 3'd2; step();
    check("ovf_ninth_absent", 32'(rd_x), 32'h0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Ordering and interruption.
    reset = 1'b1; step(); reset = 1'b0;
    check("reset_clears_ovf", 32'(overflow), 32'd0);
    vblank = 1'b0;
    wr(16'h0020, 16'h0001);
    wr(16'h0020, 16'h0002);
    wr(16'h0021, 16'h0003);
    vblank = 1'b1;
    step(3);
    vblank = 1'b0;
    check("order_pending", 32'(pending), 32'd1);
    rd_sprite = 3'd0; step();
    check("order_s0_x", 32'(rd_x), 32'h0002);
    check("order_s0_y_old", 32'(rd_y), 32'h0);
    vblank = 1'b1;
    step(3);
    check("order_s0_y", 32'(rd_y), 32'h0003);
    check("order_empty", 32'(pending), 32'd0);

    // Reset on the second drain cycle.
    vblank = 1'b0; rd_sprite = 3'd3;
    for (int i = 0; i < 5; i++) wr(16'(16'h002C + i), 16'(16'h00A0 + i));
    vblank = 1'b1;
    step(2);
    reset = 1'b1; step(); reset = 1'b0;
    check("rst_mid_pending",  32'(pending),  32'd0);
    check("rst_mid_overflow", 32'(overflow), 32'd0);
    check("rst_mid_rd_x",     32'(rd_x),     32'd0);
    step(2);
    check("rst_mid_table_x",  32'(rd_x),     32'd0);
    check("rst_mid_idle",     32'(pending),  32'd0);

    // Randomised traffic with long vblank runs.
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) vblank = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 15) == 0) vblank = ~vblank;
      write = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) wr_addr = 16'($urandom);
      else wr_addr = 16'h0020 | 16'($urandom_range(0, 31));
      wr_data   = 16'($urandom);
      rd_sprite = 3'($urandom);
      reset     = ($urandom_range(0, 499) == 0);
      step();
    end
    write = 1'b0; reset = 1'b0;
    step(2);
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
